// File: rtl/cpu_run_monitor.sv
// Run controller beside the core: sequences core reset, counts run cycles and
// event channels, and ends the run on halt, PC self-loop or cycle timeout.
//
// Ports:
//   clk, rst (async, active high), restart (sync pulse)
//   cpu_rst   : registered reset to the core
//   pc        : core program counter
//   halt_req  : core halt indication
//   event_in  : per-channel event strobes
//   sel       : readout channel select
//   count_out : registered counter[sel] (0 when sel >= NUM_CH)
//   cycles    : run-cycle count
//   state     : 0=HOLD 1=RUN 2=HALTED 3=TIMEOUT
//   done      : HALTED or TIMEOUT
//   timed_out : TIMEOUT only
module cpu_run_monitor #(
    parameter int CNT_W       = 32,
    parameter int NUM_CH      = 4,
    parameter int PC_W        = 32,
    parameter int RST_CYCLES  = 4,
    parameter int LOOP_CYCLES = 8,
    parameter int MAX_CYCLES  = 1000
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      restart,
    output logic                                      cpu_rst,
    input  logic [PC_W-1:0]                           pc,
    input  logic                                      halt_req,
    input  logic [NUM_CH-1:0]                         event_in,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sel,
    output logic [CNT_W-1:0]                          count_out,
    output logic [CNT_W-1:0]                          cycles,
    output logic [1:0]                                state,
    output logic                                      done,
    output logic                                      timed_out
);

    localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HOLD_W  = $clog2(RST_CYCLES + 1);
    localparam int LOOP_W  = (LOOP_CYCLES > 1) ? $clog2(LOOP_CYCLES) : 1;
    localparam int LOOP_M1 = (LOOP_CYCLES > 0) ? LOOP_CYCLES - 1 : 0;
    localparam int MAX_M1  = (MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RUN     = 2'd1,
        S_HALTED  = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_cpu_rst;
    logic                r_done;
    logic                r_timed_out;
    logic [HOLD_W-1:0]   r_hold;
    logic [LOOP_W-1:0]   r_loop;
    logic [PC_W-1:0]     r_prev_pc;
    logic [CNT_W-1:0]    r_cycles;
    logic [CNT_W-1:0]    r_cnt [NUM_CH];
    logic [CNT_W-1:0]    r_count_out;
    logic [CNT_W-1:0]    w_sel_val;
    logic                w_pc_eq;
    logic                w_loop_hit;
    logic                w_tmo_hit;

    assign w_pc_eq    = (pc == r_prev_pc);
    // The loop counter holds the number of earlier equal compares, so the
    // LOOP_CYCLES-th consecutive equal compare sees LOOP_CYCLES-1 here.
    assign w_loop_hit = (LOOP_CYCLES != 0) && w_pc_eq &&
                        (r_loop == LOOP_W'(LOOP_M1));
    assign w_tmo_hit  = (MAX_CYCLES != 0) &&
                        (r_cycles == CNT_W'(MAX_M1));

    always_comb begin
        w_next = r_state;
        if (restart) begin
            w_next = S_HOLD;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_hold == HOLD_W'(RST_CYCLES - 1))
                        w_next = S_RUN;
                end
                S_RUN: begin
                    if (halt_req)
                        w_next = S_HALTED;
                    else if (w_loop_hit)
                        w_next = S_HALTED;
                    else if (w_tmo_hit)
                        w_next = S_TIMEOUT;
                end
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_HOLD;
            r_cpu_rst   <= 1'b1;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cpu_rst   <= (w_next == S_HOLD);
            r_done      <= (w_next == S_HALTED) || (w_next == S_TIMEOUT);
            r_timed_out <= (w_next == S_TIMEOUT);
        end
    end

    always_comb begin
        w_sel_val = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i))
                w_sel_val = r_cnt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold      <= '0;
            r_loop      <= '0;
            r_prev_pc   <= '0;
            r_cycles    <= '0;
            r_count_out <= '0;
            for (int i = 0; i < NUM_CH; i++)
                r_cnt[i] <= '0;
        end else if (restart) begin
            r_hold      <= '0;
            r_loop      <= '0;
            r_prev_pc   <= '0;
            r_cycles    <= '0;
            r_count_out <= '0;
            for (int i = 0; i < NUM_CH; i++)
                r_cnt[i] <= '0;
        end else begin
            // Readout samples pre-update counter values.
            r_count_out <= w_sel_val;
            if (r_state == S_HOLD) begin
                r_hold <= r_hold + 1'b1;
            end else if (r_state == S_RUN) begin
                if (r_cycles != '1)
                    r_cycles <= r_cycles + 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (event_in[i] && (r_cnt[i] != '1))
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                end
                r_prev_pc <= pc;
                if (!w_pc_eq)
                    r_loop <= '0;
                else if (r_loop != '1)
                    r_loop <= r_loop + 1'b1;
            end
        end
    end

    assign cpu_rst   = r_cpu_rst;
    assign count_out = r_count_out;
    assign cycles    = r_cycles;
    assign state     = r_state;
    assign done      = r_done;
    assign timed_out = r_timed_out;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: main instance (32-bit, LOOP 8, MAX 100)
// and a 4-bit-counter instance for saturation.
module tb_cpu_run_monitor;

    logic        clk;
    logic        rst;
    logic        restart;
    logic        cpu_rst;
    logic [31:0] pc;
    logic        halt_req;
    logic [3:0]  event_in;
    logic [1:0]  sel;
    logic [31:0] count_out;
    logic [31:0] cycles;
    logic [1:0]  state;
    logic        done;
    logic        timed_out;

    logic        s_restart;
    logic        s_cpu_rst;
    logic [31:0] s_pc;
    logic        s_halt;
    logic [3:0]  s_ev;
    logic [1:0]  s_sel;
    logic [3:0]  s_count;
    logic [3:0]  s_cycles;
    logic [1:0]  s_state;
    logic        s_done;
    logic        s_to;

    int n_cmp;
    int n_fail;

    cpu_run_monitor #(
        .CNT_W(32), .NUM_CH(4), .PC_W(32), .RST_CYCLES(4),
        .LOOP_CYCLES(8), .MAX_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst), .restart(restart), .cpu_rst(cpu_rst),
        .pc(pc), .halt_req(halt_req), .event_in(event_in), .sel(sel),
        .count_out(count_out), .cycles(cycles), .state(state),
        .done(done), .timed_out(timed_out)
    );

    cpu_run_monitor #(
        .CNT_W(4), .NUM_CH(4), .PC_W(32), .RST_CYCLES(4),
        .LOOP_CYCLES(0), .MAX_CYCLES(0)
    ) dut_sat (
        .clk(clk), .rst(rst), .restart(s_restart), .cpu_rst(s_cpu_rst),
        .pc(s_pc), .halt_req(s_halt), .event_in(s_ev), .sel(s_sel),
        .count_out(s_count), .cycles(s_cycles), .state(s_state),
        .done(s_done), .timed_out(s_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic h, input logic [3:0] ev);
        pc       = pc + 32'd4;
        halt_req = h;
        event_in = ev;
        step();
        halt_req = 1'b0;
    endtask

    task automatic do_restart();
        restart  = 1'b1;
        halt_req = 1'b0;
        event_in = 4'd0;
        step();
        restart = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (state !== 2'd0 || cpu_rst !== 1'b1 || cycles !== 32'd0 ||
            done !== 1'b0 || timed_out !== 1'b0 || count_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_vals: state=%0d cpu_rst=%0b cycles=%0d done=%0b to=%0b cnt=%0d",
                     state, cpu_rst, cycles, done, timed_out, count_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (state !== 2'd0 || cpu_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold3: state=%0d cpu_rst=%0b want 0/1", state, cpu_rst);
        end
        step();
        n_cmp++;
        if (state !== 2'd1 || cpu_rst !== 1'b0 || cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_edge4: state=%0d cpu_rst=%0b cycles=%0d want 1/0/0",
                     state, cpu_rst, cycles);
        end
    endtask

    task automatic test_events();
        do_restart();
        repeat (10) cyc(1'b0, 4'b0101);
        n_cmp++;
        if (cycles !== 32'd10) begin
            n_fail++;
            $display("FAIL ev_cycles: got %0d want 10", cycles);
        end
        sel = 2'd2;
        cyc(1'b0, 4'd0);
        n_cmp++;
        if (count_out !== 32'd10) begin
            n_fail++;
            $display("FAIL ev_ch2: got %0d want 10", count_out);
        end
        sel = 2'd1;
        cyc(1'b0, 4'd0);
        n_cmp++;
        if (count_out !== 32'd0) begin
            n_fail++;
            $display("FAIL ev_ch1: got %0d want 0", count_out);
        end
        sel = 2'd3;
        cyc(1'b0, 4'd0);
        n_cmp++;
        if (count_out !== 32'd0) begin
            n_fail++;
            $display("FAIL ev_ch3: got %0d want 0", count_out);
        end
        sel = 2'd0;
        cyc(1'b0, 4'b0001);
        n_cmp++;
        if (count_out !== 32'd10) begin
            n_fail++;
            $display("FAIL ev_preupdate: got %0d want 10", count_out);
        end
        cyc(1'b0, 4'd0);
        n_cmp++;
        if (count_out !== 32'd11 || cycles !== 32'd15) begin
            n_fail++;
            $display("FAIL ev_ch0_post: cnt=%0d cycles=%0d want 11/15", count_out, cycles);
        end
    endtask

    task automatic test_halt();
        do_restart();
        sel = 2'd0;
        repeat (19) cyc(1'b0, 4'hF);
        n_cmp++;
        if (state !== 2'd1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_pre: state=%0d done=%0b want 1/0", state, done);
        end
        cyc(1'b1, 4'hF);
        n_cmp++;
        if (state !== 2'd2 || done !== 1'b1 || timed_out !== 1'b0 ||
            cycles !== 32'd20 || cpu_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_exit: state=%0d done=%0b to=%0b cycles=%0d cpu_rst=%0b want 2/1/0/20/0",
                     state, done, timed_out, cycles, cpu_rst);
        end
        repeat (5) cyc(1'b0, 4'hF);
        n_cmp++;
        if (state !== 2'd2 || cycles !== 32'd20 || count_out !== 32'd20) begin
            n_fail++;
            $display("FAIL halt_frozen: state=%0d cycles=%0d cnt=%0d want 2/20/20",
                     state, cycles, count_out);
        end
    endtask

    task automatic test_loop();
        do_restart();
        for (int i = 0; i < 30; i++) begin
            pc       = i[0] ? 32'h20 : 32'h10;
            halt_req = 1'b0;
            event_in = 4'd0;
            step();
        end
        pc = 32'h40;
        repeat (8) step();
        n_cmp++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL loop_7eq: state=%0d want 1", state);
        end
        step();
        n_cmp++;
        if (state !== 2'd2 || timed_out !== 1'b0 || done !== 1'b1 ||
            cycles !== 32'd39) begin
            n_fail++;
            $display("FAIL loop_8eq: state=%0d to=%0b done=%0b cycles=%0d want 2/0/1/39",
                     state, timed_out, done, cycles);
        end
    endtask

    task automatic test_timeout();
        do_restart();
        repeat (99) cyc(1'b0, 4'd0);
        n_cmp++;
        if (state !== 2'd1 || cycles !== 32'd99) begin
            n_fail++;
            $display("FAIL tmo_pre: state=%0d cycles=%0d want 1/99", state, cycles);
        end
        cyc(1'b0, 4'd0);
        n_cmp++;
        if (state !== 2'd3 || done !== 1'b1 || timed_out !== 1'b1 ||
            cycles !== 32'd100) begin
            n_fail++;
            $display("FAIL tmo_exit: state=%0d done=%0b to=%0b cycles=%0d want 3/1/1/100",
                     state, done, timed_out, cycles);
        end
        cyc(1'b1, 4'd0);
        n_cmp++;
        if (state !== 2'd3 || cycles !== 32'd100) begin
            n_fail++;
            $display("FAIL tmo_frozen: state=%0d cycles=%0d want 3/100", state, cycles);
        end
    endtask

    task automatic test_halt_vs_timeout();
        do_restart();
        repeat (99) cyc(1'b0, 4'd0);
        cyc(1'b1, 4'd0);
        n_cmp++;
        if (state !== 2'd2 || timed_out !== 1'b0 || cycles !== 32'd100) begin
            n_fail++;
            $display("FAIL halt_prio: state=%0d to=%0b cycles=%0d want 2/0/100",
                     state, timed_out, cycles);
        end
    endtask

    task automatic test_restart();
        do_restart();
        sel = 2'd0;
        repeat (50) cyc(1'b0, 4'b0001);
        restart  = 1'b1;
        halt_req = 1'b1;
        step();
        restart  = 1'b0;
        halt_req = 1'b0;
        n_cmp++;
        if (state !== 2'd0 || cpu_rst !== 1'b1 || cycles !== 32'd0 ||
            count_out !== 32'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rs_clear: state=%0d cpu_rst=%0b cycles=%0d cnt=%0d done=%0b want 0/1/0/0/0",
                     state, cpu_rst, cycles, count_out, done);
        end
        repeat (3) step();
        n_cmp++;
        if (state !== 2'd0 || cpu_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL rs_hold: state=%0d cpu_rst=%0b want 0/1", state, cpu_rst);
        end
        step();
        n_cmp++;
        if (state !== 2'd1 || cpu_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL rs_run: state=%0d cpu_rst=%0b want 1/0", state, cpu_rst);
        end
        cyc(1'b0, 4'd0);
        n_cmp++;
        if (count_out !== 32'd0 || cycles !== 32'd1) begin
            n_fail++;
            $display("FAIL rs_cnt: cnt=%0d cycles=%0d want 0/1", count_out, cycles);
        end
    endtask

    task automatic test_async_rst();
        do_restart();
        sel = 2'd0;
        repeat (5) cyc(1'b0, 4'b0001);
        cyc(1'b0, 4'd0);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (state !== 2'd0 || cpu_rst !== 1'b1 || cycles !== 32'd0 ||
            count_out !== 32'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_clear: state=%0d cpu_rst=%0b cycles=%0d cnt=%0d done=%0b",
                     state, cpu_rst, cycles, count_out, done);
        end
        step();
        rst = 1'b0;
        repeat (4) step();
        n_cmp++;
        if (state !== 2'd1 || cpu_rst !== 1'b0 || cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL arst_rerun: state=%0d cpu_rst=%0b cycles=%0d want 1/0/0",
                     state, cpu_rst, cycles);
        end
    endtask

    task automatic test_saturation();
        s_restart = 1'b1;
        step();
        s_restart = 1'b0;
        repeat (4) step();
        n_cmp++;
        if (s_state !== 2'd1 || s_cycles !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_start: state=%0d cycles=%0d want 1/0", s_state, s_cycles);
        end
        s_ev = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            s_pc = s_pc + 32'd4;
            step();
            if (i == 13) begin
                n_cmp++;
                if (s_cycles !== 4'd14) begin
                    n_fail++;
                    $display("FAIL sat_mid: got %0d want 14", s_cycles);
                end
            end
        end
        s_ev  = 4'd0;
        s_sel = 2'd0;
        step();
        n_cmp++;
        if (s_count !== 4'd15 || s_cycles !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_end: cnt=%0d cycles=%0d want 15/15", s_count, s_cycles);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        restart   = 1'b0;
        pc        = 32'd0;
        halt_req  = 1'b0;
        event_in  = 4'd0;
        sel       = 2'd0;
        s_restart = 1'b0;
        s_pc      = 32'd0;
        s_halt    = 1'b0;
        s_ev      = 4'd0;
        s_sel     = 2'd0;
        test_reset();
        test_events();
        test_halt();
        test_loop();
        test_timeout();
        test_halt_vs_timeout();
        test_restart();
        test_async_rst();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
- Synthesizable, parametrised run controller that sits beside the processor core in the top-level harness.
- Sequences the core's reset for a programmable number of cycles, then counts run cycles and NUM_CH event channels.
- Ends the run on an explicit halt, a PC self-loop, or a cycle timeout, freezing all counters for readout.
- Generalises the bench's free-running cycle count into configurable-width, multi-channel, terminating hardware.

Parameters:
- CNT_W, 32, width of the cycle counter and of each event counter.
- NUM_CH, 4, number of event counter channels (>=1).
- PC_W, 32, width of the observed program counter.
- RST_CYCLES, 4, number of rising edges cpu_rst is held high after rst/restart (>=1).
- LOOP_CYCLES, 8, consecutive unchanged-PC cycles that count as a halt; 0 disables loop detection.
- MAX_CYCLES, 1000, run-cycle limit before timeout; 0 disables timeout.

Ports:
- clk  in  1  system clock, all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- restart  in  1  synchronous pulse; re-runs the full sequence from any state.
- cpu_rst  out  1  registered reset to the core.
- pc  in  PC_W  core program counter.
- halt_req  in  1  core halt indication.
- event_in  in  NUM_CH  per-channel event strobes, one count per cycle high.
- sel  in  max(1,clog2(NUM_CH))  channel select for readout.
- count_out  out  CNT_W  registered value of channel sel.
- cycles  out  CNT_W  run-cycle count.
- state  out  2  run state: 0=HOLD, 1=RUN, 2=HALTED, 3=TIMEOUT.
- done  out  1  high in HALTED or TIMEOUT.
- timed_out  out  1  high only in TIMEOUT.

Behaviour:
- rst high, immediately and asynchronously:
  - state=HOLD, cpu_rst=1.
  - hold counter, cycles, all event counters, loop counter, count_out = 0.
  - done=0, timed_out=0, previous-PC register = 0.
- HOLD:
  - hold counter increments each edge.
  - On the edge where hold counter == RST_CYCLES-1: state->RUN and cpu_rst->0.
  - cpu_rst therefore falls on the RST_CYCLES-th rising edge after rst release.
  - No counting occurs in HOLD; halt_req, pc and event_in are ignored.
- RUN, every edge:
  - cycles += 1, saturating at all-ones.
  - Each counter[i] += event_in[i], saturating at all-ones.
  - This includes the edge on which RUN is exited.
- Loop detection (RUN only):
  - If pc equals the previous-PC register, loop counter += 1; otherwise it clears to 0.
  - The previous-PC register loads pc every RUN cycle.
  - The first RUN cycle always compares against the register value 0.
- Exit conditions evaluated at each RUN edge, priority highest first:
  - halt_req==1 -> HALTED.
  - LOOP_CYCLES!=0 and loop counter==LOOP_CYCLES-1 with pc unchanged -> HALTED.
  - MAX_CYCLES!=0 and cycles==MAX_CYCLES-1 -> TIMEOUT. The final cycles value is MAX_CYCLES.
- HALTED / TIMEOUT:
  - All counters frozen; cpu_rst stays 0.
  - done=1; timed_out=1 in TIMEOUT only.
  - Exit only via rst or restart.
- restart (synchronous), sampled high in any state:
  - Next edge: state=HOLD, cpu_rst=1, all counters/flags cleared as in reset.
  - The hold count starts from 0 on the following edge.
  - restart takes priority over every RUN transition on the same edge.
- Readout:
  - count_out <= counter[sel] every edge, in all states (1-cycle latency).
  - sel >= NUM_CH returns 0.
  - In the same cycle a counter updates, count_out reflects the pre-update value.
- done, timed_out and state are registered and change on the same edge as the state transition.

Test Plan:
- Reset sequence, RST_CYCLES=4: release rst, hold halt_req/event_in at 0 and pc at 0.
  -> cpu_rst falls on edge 4; state=1 from that edge; cycles=0 at that point.
- Event counting, NUM_CH=4: drive event_in=4'b0101 for 10 RUN cycles, toggling pc each cycle; keep LOOP_CYCLES and MAX_CYCLES large.
  -> counters = {0,10,0,10} for ch3..ch0; sel=2 gives count_out=10 one cycle later; sel=1 gives 0.
- Explicit halt: pulse halt_req on RUN cycle 20 while events are active.
  -> state=2, done=1, cycles=20 and frozen; events driven afterwards are not counted.
- PC self-loop, LOOP_CYCLES=8: pc alternates until cycle 30, then holds at 0x40.
  -> state=2 after the 8th consecutive equal compare; timed_out=0.
- Timeout, MAX_CYCLES=100: pc keeps changing and halt_req is never asserted.
  -> state=3, done=1, timed_out=1, cycles=100. halt_req and timeout on the same edge -> state=2.
- Restart and rst mid-run: pulse restart at RUN cycle 50.
  -> next edge state=0, cpu_rst=1, cycles=0, counters=0, then a 4-cycle hold.
  - Asserting rst asynchronously between edges clears all outputs immediately.
- Saturation, CNT_W=4: hold event_in[0]=1 for 20 RUN cycles.
  -> counter[0]=15 and cycles=15, with no wrap.
